// File: rtl/imm_narrow_32to6.sv
// Narrows a signed DATA_W value to a signed IMM_W immediate through a one-entry valid/ready stage.
// Optional build macro IMM_NARROW_SATURATE_EN: overflowing inputs saturate instead of truncating.
module imm_narrow_32to6 #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IMM_W-1:0]  out_imm,
  output logic              out_ovf,
  output logic              ovf_sticky,
  output logic [CNT_W-1:0]  ovf_cnt,
  input  logic              clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Upper bits including the immediate's sign bit must all agree for the value to fit.
  logic [DATA_W-IMM_W:0] upper;
  logic                  fits;
  logic                  accept;
  logic                  ovf_evt;
  logic [IMM_W-1:0]      imm_next;

  assign upper   = in_data[DATA_W-1:IMM_W-1];
  assign fits    = (&upper) || ~(|upper);
  assign in_ready = !out_valid || out_ready;
  assign accept  = in_valid && in_ready;
  assign ovf_evt = accept && !fits;

`ifdef IMM_NARROW_SATURATE_EN
  localparam logic [IMM_W-1:0] IMM_MAX = {1'b0, {(IMM_W-1){1'b1}}};
  localparam logic [IMM_W-1:0] IMM_MIN = {1'b1, {(IMM_W-1){1'b0}}};

  always_comb begin
    imm_next = in_data[IMM_W-1:0];
    if (!fits) imm_next = in_data[DATA_W-1] ? IMM_MIN : IMM_MAX;
  end
`else
  always_comb begin
    imm_next = in_data[IMM_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_imm   <= imm_next;
      out_ovf   <= !fits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A new overflow in the clear cycle survives the clear as a count of one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else if (ovf_evt) begin
      ovf_sticky <= 1'b1;
      if (clr)                   ovf_cnt <= CNT_ONE;
      else if (ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + CNT_ONE;
    end else if (clr) begin
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end
  end

endmodule
